// File: rtl/alu_iter.sv
`default_nettype none
// alu_iter: valid/ready ALU with single-cycle logic/arith/shift ops plus
// iterative shift-add multiply and restoring divide (one bit per cycle).
module alu_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_lo,
  output logic [WIDTH-1:0] out_hi,
  output logic [3:0]       flags
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_NOT  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_LSHR = 4'd7;
  localparam logic [3:0] OP_ASHR = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_DIV  = 4'd10;
  localparam logic [3:0] OP_CMP  = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       mode_q, mode_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] out_lo_q, out_lo_d, out_hi_q, out_hi_d;
  logic [3:0]       flags_q, flags_d;

  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] s_lo, s_hi;
  logic             s_carry, s_div0, s_known, s_zero, s_neg;
  logic [3:0]       s_flags;

  // Single-cycle results are computed from the live inputs and land in the
  // output registers on the accept edge itself.
  always_comb begin
    add_w   = {1'b0, a} + {1'b0, b};
    sub_w   = {1'b0, a} - {1'b0, b};
    s_lo    = '0;
    s_hi    = '0;
    s_carry = 1'b0;
    s_div0  = 1'b0;
    s_known = 1'b1;
    case (mode)
      OP_NOT:  s_lo = ~a;
      OP_OR:   s_lo = a | b;
      OP_AND:  s_lo = a & b;
      OP_XOR:  s_lo = a ^ b;
      OP_ADD:  {s_carry, s_lo} = add_w;
      OP_SUB:  {s_carry, s_lo} = sub_w;
      OP_CMP: begin
        s_lo    = a;
        s_carry = sub_w[WIDTH];
      end
      OP_SHL: begin
        s_lo    = {a[WIDTH-2:0], 1'b0};
        s_carry = a[WIDTH-1];
      end
      OP_LSHR: begin
        s_lo    = {1'b0, a[WIDTH-1:1]};
        s_carry = a[0];
      end
      OP_ASHR: begin
        s_lo    = {a[WIDTH-1], a[WIDTH-1:1]};
        s_carry = a[0];
      end
      OP_DIV: begin
        s_lo   = '1;
        s_hi   = a;
        s_div0 = 1'b1;
      end
      default: s_known = 1'b0;
    endcase
    s_zero  = (mode == OP_CMP) ? (a == b) : (s_lo == '0);
    s_neg   = (mode == OP_CMP) ? sub_w[WIDTH-1] : s_lo[WIDTH-1];
    s_flags = s_known ? {s_div0, s_neg, s_zero, s_carry} : 4'b0000;
  end

  logic [WIDTH:0]   mul_sum, div_sh;
  logic [WIDTH-1:0] div_diff, it_lo, it_hi;
  logic             div_ge;

  // One iteration step. MUL: hi accumulates, lo holds the multiplier and
  // collects product bits. DIV: hi is the partial remainder, lo shifts the
  // dividend out and quotient bits in.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_sh   = {hi_q, lo_q[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, b_q});
    div_diff = div_sh[WIDTH-1:0] - b_q;
    if (mode_q == OP_MUL) begin
      it_hi = mul_sum[WIDTH:1];
      it_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      it_hi = div_ge ? div_diff : div_sh[WIDTH-1:0];
      it_lo = {lo_q[WIDTH-2:0], div_ge};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    out_lo_d = out_lo_q;
    out_hi_d = out_hi_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d    = a;
          b_d    = b;
          mode_d = mode;
          cnt_d  = '0;
          if (mode == OP_MUL) begin
            state_d = BUSY;
            hi_d    = '0;
            lo_d    = b;
          end else if (mode == OP_DIV && b != '0) begin
            state_d = BUSY;
            hi_d    = '0;
            lo_d    = a;
          end else begin
            state_d  = DONE;
            out_lo_d = s_lo;
            out_hi_d = s_hi;
            flags_d  = s_flags;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        hi_d  = it_hi;
        lo_d  = it_lo;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          out_lo_d = it_lo;
          out_hi_d = it_hi;
          flags_d  = {1'b0, it_lo[WIDTH-1], (it_lo == '0),
                      (mode_q == OP_MUL) && (it_hi != '0)};
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      out_lo_q <= '0;
      out_hi_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      out_lo_q <= out_lo_d;
      out_hi_q <= out_hi_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_lo    = out_lo_q;
  assign out_hi    = out_hi_q;
  assign flags     = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_iter.sv
`default_nettype none
// tb_alu_iter: directed-vector bench for alu_iter at WIDTH=8.
module tb_alu_iter;

  localparam logic [3:0] OP_NOT  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_LSHR = 4'd7;
  localparam logic [3:0] OP_ASHR = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_DIV  = 4'd10;
  localparam logic [3:0] OP_CMP  = 4'd11;
  localparam logic [3:0] OP_BAD  = 4'd12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b;
  logic [3:0] mode;
  logic       in_valid, out_ready;
  logic       in_ready, out_valid;
  logic [7:0] out_lo, out_hi;
  logic [3:0] flags;

  int total = 0;
  int bad   = 0;

  alu_iter #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_lo(out_lo), .out_hi(out_hi), .flags(flags)
  );

  always #5 clk = ~clk;

  // Issues one request (called #1 after a rising edge, DUT idle), waits a
  // bounded time for out_valid, captures the result, then handshakes it.
  task automatic do_op(input logic [3:0] m, input logic [7:0] av, input logic [7:0] bv,
                       output int lat, output logic [7:0] lo, output logic [7:0] hi,
                       output logic [3:0] fl);
    a = av; b = bv; mode = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    lo = out_lo; hi = out_hi; fl = flags;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++; $display("FAIL reset ready/valid got=%b exp=10", {in_ready, out_valid});
    end
    total++;
    if ({out_lo, out_hi, flags} !== 20'h0) begin
      bad++; $display("FAIL reset outputs got=%h exp=00000", {out_lo, out_hi, flags});
    end
    rst_n = 1'b1;
  endtask

  task automatic run_vectors(input string tag, input int n,
                             input logic [3:0] vm[12], input logic [7:0] va[12],
                             input logic [7:0] vb[12], input logic [7:0] vlo[12],
                             input logic [7:0] vhi[12], input logic [3:0] vf[12],
                             input int vlat[12]);
    int lat; logic [7:0] lo, hi; logic [3:0] fl;
    for (int i = 0; i < n; i++) begin
      do_op(vm[i], va[i], vb[i], lat, lo, hi, fl);
      total++;
      if (lat !== vlat[i]) begin
        bad++; $display("FAIL %s[%0d] latency got=%0d exp=%0d", tag, i, lat, vlat[i]);
      end
      total++;
      if (lo !== vlo[i]) begin
        bad++; $display("FAIL %s[%0d] out_lo got=%h exp=%h", tag, i, lo, vlo[i]);
      end
      total++;
      if (hi !== vhi[i]) begin
        bad++; $display("FAIL %s[%0d] out_hi got=%h exp=%h", tag, i, hi, vhi[i]);
      end
      total++;
      if (fl !== vf[i]) begin
        bad++; $display("FAIL %s[%0d] flags got=%b exp=%b", tag, i, fl, vf[i]);
      end
    end
  endtask

  task automatic test_logic;
    logic [3:0] vm[12], vf[12]; logic [7:0] va[12], vb[12], vlo[12], vhi[12]; int vlat[12];
    vm  = '{OP_NOT, OP_OR, OP_AND, OP_XOR, 0, 0, 0, 0, 0, 0, 0, 0};
    va  = '{8'h5A, 8'hF0, 8'hF0, 8'h3C, 0, 0, 0, 0, 0, 0, 0, 0};
    vb  = '{8'h00, 8'h0F, 8'h0F, 8'h3C, 0, 0, 0, 0, 0, 0, 0, 0};
    vlo = '{8'hA5, 8'hFF, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0};
    vhi = '{default: 8'h00};
    vf  = '{4'b0100, 4'b0100, 4'b0010, 4'b0010, 0, 0, 0, 0, 0, 0, 0, 0};
    vlat = '{default: 1};
    run_vectors("logic", 4, vm, va, vb, vlo, vhi, vf, vlat);
  endtask

  task automatic test_arith;
    logic [3:0] vm[12], vf[12]; logic [7:0] va[12], vb[12], vlo[12], vhi[12]; int vlat[12];
    vm  = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_SHL, OP_LSHR, OP_ASHR, OP_ASHR,
            OP_BAD, OP_CMP, OP_CMP, 0};
    va  = '{8'hFF, 8'h40, 8'h05, 8'h09, 8'h81, 8'h81, 8'h81, 8'h40, 8'hFF, 8'h05, 8'h33, 0};
    vb  = '{8'h01, 8'h3F, 8'h09, 8'h05, 8'h55, 8'h55, 8'h55, 8'h55, 8'hFF, 8'h09, 8'h33, 0};
    vlo = '{8'h00, 8'h7F, 8'hFC, 8'h04, 8'h02, 8'h40, 8'hC0, 8'h20, 8'h00, 8'h05, 8'h33, 0};
    vhi = '{default: 8'h00};
    vf  = '{4'b0011, 4'b0000, 4'b0101, 4'b0000, 4'b0001, 4'b0001, 4'b0101, 4'b0000,
            4'b0000, 4'b0101, 4'b0010, 0};
    vlat = '{default: 1};
    run_vectors("arith", 11, vm, va, vb, vlo, vhi, vf, vlat);
  endtask

  task automatic test_muldiv;
    logic [3:0] vm[12], vf[12]; logic [7:0] va[12], vb[12], vlo[12], vhi[12]; int vlat[12];
    vm  = '{OP_MUL, OP_MUL, OP_MUL, OP_DIV, OP_DIV, OP_DIV, OP_DIV, 0, 0, 0, 0, 0};
    va  = '{8'h0F, 8'hFF, 8'h00, 8'd200, 8'h05, 8'h2A, 8'hFF, 0, 0, 0, 0, 0};
    vb  = '{8'h11, 8'hFF, 8'h05, 8'd7, 8'h09, 8'h00, 8'h01, 0, 0, 0, 0, 0};
    vlo = '{8'hFF, 8'h01, 8'h00, 8'h1C, 8'h00, 8'hFF, 8'hFF, 0, 0, 0, 0, 0};
    vhi = '{8'h00, 8'hFE, 8'h00, 8'h04, 8'h05, 8'h2A, 8'h00, 0, 0, 0, 0, 0};
    vf  = '{4'b0100, 4'b0001, 4'b0010, 4'b0000, 4'b0010, 4'b1100, 4'b0100, 0, 0, 0, 0, 0};
    vlat = '{9, 9, 9, 9, 9, 1, 9, 0, 0, 0, 0, 0};
    run_vectors("muldiv", 7, vm, va, vb, vlo, vhi, vf, vlat);
  endtask

  task automatic test_backpressure;
    a = 8'h10; b = 8'h20; mode = OP_ADD; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL bp first_valid got=%b exp=1", out_valid);
    end
    for (int k = 0; k < 5; k++) begin
      a = 8'($urandom); b = 8'($urandom); mode = 4'($urandom); in_valid = (k % 2 == 0);
      @(posedge clk); #1;
      total++;
      if ({out_valid, in_ready, out_lo, out_hi, flags} !== {2'b10, 8'h30, 8'h00, 4'b0000}) begin
        bad++;
        $display("FAIL bp hold[%0d] got=%b_%b_%h_%h_%b exp=1_0_30_00_0000",
                 k, out_valid, in_ready, out_lo, out_hi, flags);
      end
    end
    a = 8'h01; b = 8'h01; mode = OP_ADD; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL bp release got=%b exp=01", {out_valid, in_ready});
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL bp no_accept_on_handshake got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_reset_busy;
    int lat; logic [7:0] lo, hi; logic [3:0] fl; logic seen;
    a = 8'hFF; b = 8'hFF; mode = OP_MUL; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if ({in_ready, out_valid, out_lo} !== {2'b00, 8'h30}) begin
      bad++; $display("FAIL rstbusy pre got=%b_%b_%h exp=0_0_30", in_ready, out_valid, out_lo);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, out_lo, out_hi, flags} !== {2'b10, 20'h0}) begin
      bad++;
      $display("FAIL rstbusy async got=%b_%b_%h_%h_%b exp=1_0_00_00_0000",
               in_ready, out_valid, out_lo, out_hi, flags);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL rstbusy stale_result got=%b exp=0", seen);
    end
    do_op(OP_ADD, 8'h02, 8'h03, lat, lo, hi, fl);
    total++;
    if ({lat[3:0], lo, hi, fl} !== {4'd1, 8'h05, 8'h00, 4'b0000}) begin
      bad++; $display("FAIL rstbusy add got=%0d_%h_%h_%b exp=1_05_00_0000", lat, lo, hi, fl);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; mode = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_logic;
    test_arith;
    test_muldiv;
    test_backpressure;
    test_reset_busy;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
